gene_pruner: RTL and testbench

GENE_PRUNER -- requirements
Module: gene_pruner

---
 rtl/gene_pruner.sv | 176 +++++++++++++++++
 tb/tb_gene_pruner.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gene_pruner.sv
// gene_pruner: streams a genome of node and connection genes, drops node genes
// marked for deletion (recording them in an external deleted-node table) and
// connection genes touching a deleted node, and forwards the survivors through
// a 2-entry skid buffer. Optional statistics counters are built only when
// GENE_PRUNER_STATS_EN is defined; otherwise kept_cnt/pruned_cnt read as 0.
module gene_pruner #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_conn,
  input  logic                  in_delete,
  input  logic [DATA_WIDTH-1:0] in_id1,
  input  logic [DATA_WIDTH-1:0] in_id2,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_conn,
  output logic [DATA_WIDTH-1:0] out_id1,
  output logic [DATA_WIDTH-1:0] out_id2,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] tbl_id1,
  output logic [DATA_WIDTH-1:0] tbl_id2,
  output logic                  tbl_add,
  output logic                  tbl_clear,
  input  logic                  tbl_match,
  input  logic                  tbl_full,
  output logic                  overflow,
  output logic                  order_err,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  kept_cnt,
  output logic [CNT_WIDTH-1:0]  pruned_cnt
);

  typedef enum logic [1:0] {IDLE, NODES, CONNS, DONE} state_t;

  typedef struct packed {
    logic                  conn;
    logic [DATA_WIDTH-1:0] id1;
    logic [DATA_WIDTH-1:0] id2;
    logic                  last;
  } gene_t;

  state_t state;

  // evaluation register
  logic                  e_valid, e_conn, e_delete, e_last;
  logic [DATA_WIDTH-1:0] e_id1, e_id2;

  // skid buffer
  gene_t       sb_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  sb_cnt;

  logic ord_viol, node_drop, drop, slot_free, move, push, pop;

  // A node gene seen after connections have started is an ordering error and
  // is passed through untouched.
  assign ord_viol  = !e_conn && (state == CONNS);
  assign node_drop = !e_conn && e_delete && !ord_viol && !tbl_full && !tbl_match;
  assign drop      = e_conn ? tbl_match : node_drop;
  assign pop       = out_valid && out_ready;
  assign slot_free = (sb_cnt != 2'd2) || pop;
  // No evaluation during DONE: the table is being cleared that cycle, so a
  // waiting first gene of the next genome must not see stale entries.
  assign move      = e_valid && (state != DONE) && (drop || slot_free);
  assign push      = move && !drop;
  assign in_ready  = !e_valid || move;

  assign tbl_id1 = e_id1;
  assign tbl_id2 = e_conn ? e_id2 : e_id1;
  assign tbl_add = move && node_drop;

  assign out_valid = (sb_cnt != 2'd0);
  assign out_conn  = sb_mem[rd_ptr].conn;
  assign out_id1   = sb_mem[rd_ptr].id1;
  assign out_id2   = sb_mem[rd_ptr].id2;
  assign out_last  = sb_mem[rd_ptr].last;

  // Load the next gene into E whenever it is empty or its gene leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid  <= 1'b0;
      e_conn   <= 1'b0;
      e_delete <= 1'b0;
      e_last   <= 1'b0;
      e_id1    <= '0;
      e_id2    <= '0;
    end else if (in_ready) begin
      e_valid  <= in_valid;
      e_conn   <= in_conn;
      e_delete <= in_delete;
      e_last   <= in_last;
      e_id1    <= in_id1;
      e_id2    <= in_id2;
    end
  end

  // Skid buffer storage; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= '{conn: e_conn, id1: e_id1, id2: e_id2, last: e_last};
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      sb_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      sb_cnt <= sb_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Genome phase tracking, end-of-genome pulses and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      tbl_clear <= 1'b1;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      tbl_clear <= 1'b0;
      case (state)
        DONE: state <= IDLE;
        default: begin
          if (move) begin
            if (e_last) begin
              state     <= DONE;
              done      <= 1'b1;
              tbl_clear <= 1'b1;
            end else if (e_conn) begin
              state <= CONNS;
            end else if (state == IDLE) begin
              state <= NODES;
            end
          end
        end
      endcase
      if (move && ord_viol) order_err <= 1'b1;
      if (move && !e_conn && e_delete && !ord_viol && tbl_full && !tbl_match)
        overflow <= 1'b1;
    end
  end

`ifdef GENE_PRUNER_STATS_EN
  logic [CNT_WIDTH-1:0] kept_q, pruned_q;
  assign kept_cnt   = kept_q;
  assign pruned_cnt = pruned_q;

  // Saturating per-genome statistics, cleared along with the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kept_q   <= '0;
      pruned_q <= '0;
    end else if (tbl_clear) begin
      kept_q   <= '0;
      pruned_q <= '0;
    end else begin
      if (push && (kept_q != '1)) kept_q <= kept_q + CNT_WIDTH'(1);
      if (move && drop && (pruned_q != '1)) pruned_q <= pruned_q + CNT_WIDTH'(1);
    end
  end
`else
  assign kept_cnt   = '0;
  assign pruned_cnt = '0;
`endif

endmodule

// File: tb/tb_gene_pruner.sv
// Bench for gene_pruner: a genome-level reference model predicts the surviving
// gene stream, per-genome statistics, table additions and sticky flags; an
// environment model plays the deleted-node table.
module tb_gene_pruner;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int CAP = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_conn = 1'b0, in_delete = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_id1 = '0, in_id2 = '0;
  logic out_valid, out_ready = 1'b1, out_conn, out_last;
  logic [DW-1:0] out_id1, out_id2, tbl_id1, tbl_id2;
  logic tbl_add, tbl_clear, tbl_match, tbl_full;
  logic overflow, order_err, done;
  logic [CW-1:0] kept_cnt, pruned_cnt;

  gene_pruner #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_conn(in_conn), .in_delete(in_delete),
    .in_id1(in_id1), .in_id2(in_id2), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_conn(out_conn),
    .out_id1(out_id1), .out_id2(out_id2), .out_last(out_last),
    .tbl_id1(tbl_id1), .tbl_id2(tbl_id2), .tbl_add(tbl_add), .tbl_clear(tbl_clear),
    .tbl_match(tbl_match), .tbl_full(tbl_full),
    .overflow(overflow), .order_err(order_err), .done(done),
    .kept_cnt(kept_cnt), .pruned_cnt(pruned_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          conn;
    logic          del;
    logic [DW-1:0] id1;
    logic [DW-1:0] id2;
    logic          last;
  } gene_t;

  gene_t stim_q[$];
  gene_t exp_q[$];
  gene_t obs_q[$];
  int    exp_kept_q[$], exp_pruned_q[$], exp_adds_q[$];
  bit    exp_ovf = 0, exp_ord = 0;

  int vectors = 0, miscompares = 0;
  int add_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int last_kept = 0, last_pruned = 0, last_adds = 0;
  logic force_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- deleted-node table (environment) ----------------
  bit [255:0] dset = '0;
  int         tab_cnt = 0;
  logic       p_add = 1'b0, p_clr = 1'b1;
  logic [DW-1:0] p_id = '0;

  assign tbl_match = dset[tbl_id1] | dset[tbl_id2];
  assign tbl_full  = force_full | (tab_cnt >= CAP);

  always @(negedge clk) begin
    p_add = tbl_add;
    p_clr = tbl_clear;
    p_id  = tbl_id1;
  end

  always @(posedge clk) begin
    if (p_clr) begin
      dset    <= '0;
      tab_cnt <= 0;
    end else if (p_add && !dset[p_id]) begin
      dset[p_id] <= 1'b1;
      tab_cnt    <= tab_cnt + 1;
    end
  end

  // ---------------- reference model (whole genome) ----------------
  task automatic model_genome(input bit full);
    bit [255:0] del_set = '0;
    int n = 0, k = 0, p = 0, a = 0;
    bit seen_conn = 0;
    foreach (stim_q[i]) begin
      gene_t g;
      bit keep;
      g = stim_q[i];
      if (g.conn) begin
        seen_conn = 1;
        keep = !(del_set[g.id1] || del_set[g.id2]);
      end else if (seen_conn) begin
        keep = 1; exp_ord = 1;
      end else if (!g.del || del_set[g.id1]) begin
        keep = 1;
      end else if (full || n >= CAP) begin
        keep = 1; exp_ovf = 1;
      end else begin
        keep = 0; del_set[g.id1] = 1'b1; n++; a++;
      end
      if (keep) begin exp_q.push_back(g); k++; end
      else p++;
    end
`ifdef GENE_PRUNER_STATS_EN
    exp_kept_q.push_back(k);
    exp_pruned_q.push_back(p);
`else
    exp_kept_q.push_back(0);
    exp_pruned_q.push_back(0);
`endif
    exp_adds_q.push_back(a);
  endtask

  // ---------------- per-cycle compare ----------------
  bit pstall = 0;
  logic [DW*2+1:0] phold = '0;
  always @(negedge clk) begin
    if (rst) begin
      pstall = 0;
    end else begin
      if (pstall) chk("out_hold", {out_conn, out_id1, out_id2, out_last}, phold);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL out_extra: got gene %0d/%0d expected none", out_id1, out_id2);
        end else begin
          gene_t e;
          e = exp_q.pop_front();
          chk("out_gene", {out_conn, out_id1, out_id2, out_last}, {e.conn, e.id1, e.id2, e.last});
          obs_q.push_back({out_conn, 1'b0, out_id1, out_id2, out_last});
        end
      end
      if (tbl_add) add_cnt++;
      if (done) done_cnt++;
      pstall = out_valid && !out_ready;
      phold  = {out_conn, out_id1, out_id2, out_last};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic add(input bit c, input bit d, input int a, input int b, input bit l);
    stim_q.push_back({c, d, DW'(a), DW'(b), l});
  endtask

  // Called at/after a negedge; returns just after the following negedge.
  task automatic send(input gene_t g);
    int n = 0;
    bit ok = 0;
    in_valid = 1'b1; in_conn = g.conn; in_delete = g.del;
    in_id1 = g.id1; in_id2 = g.id2; in_last = g.last;
    forever begin
      #1; ok = in_ready;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
      n++;
      if (n > 200) begin
        vectors++; miscompares++;
        $display("FAIL accept_wait: gene %0d not accepted in 200 cycles", g.id1);
        break;
      end
    end
    if (ok) acc_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk); #2; out_ready = v;
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 100) begin @(negedge clk); #1; n++; end
    if (done_cnt == d0) begin
      vectors++; miscompares++;
      $display("FAIL done_wait: got no done pulse expected one within 100 cycles");
    end else begin
      last_kept = int'(kept_cnt); last_pruned = int'(pruned_cnt); last_adds = add_cnt;
      chk("kept_cnt",   kept_cnt,   exp_kept_q.pop_front());
      chk("pruned_cnt", pruned_cnt, exp_pruned_q.pop_front());
      chk("tbl_adds",   add_cnt,    exp_adds_q.pop_front());
      chk("overflow",   overflow,   exp_ovf);
      chk("order_err",  order_err,  exp_ord);
      @(negedge clk); #1;
      chk("done_width", done, 1'b0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic run_genome(input bit full);
    force_full = full;
    obs_q.delete();
    add_cnt = 0;
    model_genome(full);
    foreach (stim_q[i]) send(stim_q[i]);
    stim_q.delete();
    wait_done();
    force_full = 1'b0;
  endtask

  task automatic load_basic();
    add(0, 1, 3, 0, 0); add(0, 0, 5, 0, 0); add(0, 1, 7, 0, 0);
    add(1, 0, 3, 5, 0); add(1, 0, 5, 7, 0); add(1, 0, 5, 5, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_tbl_clear", tbl_clear, 1'b1);
    chk("rst_tbl_add", tbl_add, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {overflow, order_err}, 2'b00);
    chk("rst_cnts", {kept_cnt, pruned_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic prune
    load_basic();
    run_genome(1'b0);
    chk("basic_nout", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("basic_out0", {obs_q[0].conn, obs_q[0].id1, obs_q[0].id2, obs_q[0].last}, {1'b0, 8'd5, 8'd0, 1'b0});
      chk("basic_out1", {obs_q[1].conn, obs_q[1].id1, obs_q[1].id2, obs_q[1].last}, {1'b1, 8'd5, 8'd5, 1'b1});
    end
    chk("basic_adds", last_adds, 2);
`ifdef GENE_PRUNER_STATS_EN
    chk("basic_pruned_lit", last_pruned, 4);
    chk("basic_kept_lit", last_kept, 2);
`endif

    // same stream under a 10-cycle downstream stall
    load_basic();
    set_rdy(1'b0);
    @(negedge clk);
    fork
      run_genome(1'b0);
      begin repeat (10) @(negedge clk); set_rdy(1'b1); end
    join

    // all-kept genome: backpressure reaches the input after two buffered genes
    for (int i = 1; i <= 5; i++) add(0, 0, i, 0, i == 5);
    acc_cnt = 0;
    set_rdy(1'b0);
    @(negedge clk);
    fork
      run_genome(1'b0);
      begin
        repeat (10) @(negedge clk);
        #1;
        chk("stall_accepted", acc_cnt, 3);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        set_rdy(1'b1);
      end
    join
    chk("stall_nout", obs_q.size(), 5);

    // duplicate delete
    @(negedge clk);
    add(0, 1, 6, 0, 0); add(0, 1, 6, 0, 1);
    run_genome(1'b0);
    chk("dup_adds", last_adds, 1);
    if (obs_q.size() >= 1)
      chk("dup_out", {obs_q[0].conn, obs_q[0].id1, obs_q[0].last}, {1'b0, 8'd6, 1'b1});
`ifdef GENE_PRUNER_STATS_EN
    chk("dup_pruned_lit", last_pruned, 1);
`endif

    // table full
    @(negedge clk);
    add(0, 1, 9, 0, 1);
    run_genome(1'b1);
    chk("full_overflow_lit", overflow, 1'b1);
    chk("full_adds", last_adds, 0);
    chk("full_nout", obs_q.size(), 1);

    // node after connection
    @(negedge clk);
    add(1, 0, 1, 2, 0); add(0, 1, 4, 0, 1);
    run_genome(1'b0);
    chk("order_err_lit", order_err, 1'b1);
    chk("order_adds", last_adds, 0);
    if (obs_q.size() >= 2)
      chk("order_out", {obs_q[1].conn, obs_q[1].id1, obs_q[1].last}, {1'b0, 8'd4, 1'b1});

    // reset mid-genome with two genes in flight
    @(negedge clk);
    set_rdy(1'b0);
    @(negedge clk);
    send({1'b0, 1'b0, 8'd1, 8'd0, 1'b0});
    send({1'b0, 1'b0, 8'd2, 8'd0, 1'b0});
    #1;
    chk("inflight_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_cnts", {kept_cnt, pruned_cnt}, 32'd0);
    chk("mid_rst_flags", {overflow, order_err}, 2'b00);
    exp_q.delete(); exp_kept_q.delete(); exp_pruned_q.delete(); exp_adds_q.delete();
    exp_ovf = 0; exp_ord = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_tbl_clear", tbl_clear, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // clean genome after reset: IDLE start, flags clear
    load_basic();
    run_genome(1'b0);
    chk("post_rst_nout", obs_q.size(), 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
